// File: rtl/rom_stream_reader.sv
// Streams a burst of consecutive bytes from a 1-cycle-latency synchronous ROM
// into a valid/ready output through a 2-entry FIFO.
module rom_stream_reader #(
  parameter int AW = 13,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [AW-1:0] req_len,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_q,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] addr;
  logic [AW-1:0] count;
  logic          inflight;
  logic          inflight_last;
  logic [DW-1:0] fifo_data [2];
  logic [1:0]    fifo_last;
  logic          rd_ptr, wr_ptr;
  logic [1:0]    fifo_cnt;
  logic [1:0]    occ_after;
  logic          accept, issue, push, pop;

  assign accept = req_valid && (state == IDLE);
  assign pop    = out_valid && out_ready;
  assign push   = inflight;

  // Occupancy the FIFO will have once this cycle's pop and the in-flight read
  // land; issuing only while it is below 2 means a push never meets a full FIFO,
  // yet still allows one read per cycle while the consumer keeps up.
  assign occ_after = fifo_cnt - 2'(pop) + 2'(inflight);
  assign issue     = (state == RUN) && (occ_after < 2'd2);

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rom_addr  = addr;
  assign out_valid = (fifo_cnt != 2'd0);
  assign out_data  = fifo_data[rd_ptr];
  assign out_last  = fifo_last[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every variable written in always_comb gets a default first, otherwise
  // a path that leaves it unassigned infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (issue && count == '0) state_nxt = DRAIN;
      DRAIN:   if (pop && out_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr          <= '0;
      count         <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue && (count == '0);
      if (accept) begin
        addr  <= req_addr;
        count <= req_len;
      end else if (issue && count != '0) begin
        // Final read leaves addr on its own address so rom_addr holds.
        addr  <= addr + 1'b1;
        count <= count - 1'b1;
      end
    end
  end

  // NOTE: the FIFO storage is reset as well because out_data reads the head
  // entry directly and must be 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_last    <= '0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      fifo_cnt     <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= rom_q;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_rom_stream_reader.sv
// Scoreboard bench for rom_stream_reader: ROM returns rom_addr[7:0] one cycle later,
// expected bytes are queued at request time and popped on each output handshake.
module tb_rom_stream_reader;

  localparam int AW = 13;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic [AW-1:0] req_len = '0;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_q = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_popped = 0;
  int ready_mode = 0;  // 0: always ready, 1: toggle, 2: held low

  logic [DW:0] sb[$];  // {last, data}

  logic          prev_stall = 1'b0;
  logic [DW:0]   prev_word  = '0;

  rom_stream_reader #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .rom_addr  (rom_addr),
    .rom_q     (rom_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_q <= rom_addr[7:0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Output monitor: scoreboard compare and stall-stability check.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_stable", {out_valid, out_last, out_data}, {1'b1, prev_word});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("sb_extra_byte", {out_last, out_data}, 32'hDEAD);
        else                check("sb_data", {out_last, out_data}, sb.pop_front());
        n_popped++;
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_last, out_data};
    end
  end

  task automatic send_req(input logic [AW-1:0] a, input logic [AW-1:0] len);
    int k;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) check("req_ready_timeout", 0, 1);
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = len;
    for (int i = 0; i <= int'(len); i++) begin
      logic [AW-1:0] ad;
      ad = a + AW'(i);
      sb.push_back({(i == int'(len)), ad[7:0]});
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) done = 1'b1;
    end
    check("burst_done", done, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    logic [AW-1:0] exp_addr [5];
    int k;

    // Reset values
    #2;
    check("rst_out_valid", out_valid, 0);
    do_reset();
    check("rst_req_ready", req_ready, 1);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_out_valid2", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);

    // Basic burst: latency and 1 byte/cycle
    send_req(13'h010, 13'd3);
    check("lat_edge0", out_valid, 0);
    check("busy_run", busy, 1);
    check("req_ready_run", req_ready, 0);
    @(posedge clk); #1;
    check("lat_edge1", out_valid, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      check("thr_valid", out_valid, 1);
      check("thr_data", out_data, 32'h10 + i);
      check("thr_last", out_last, (i == 3));
      @(posedge clk); #1;
    end
    check("basic_busy_clear", busy, 0);
    check("basic_valid_clear", out_valid, 0);
    wait_done();

    // Address wrap
    exp_addr = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001, 13'h0001};
    send_req(13'h1FFE, 13'd3);
    for (int i = 0; i < 5; i++) begin
      check("wrap_rom_addr", rom_addr, exp_addr[i]);
      @(posedge clk); #1;
    end
    wait_done();

    // Single-byte burst
    send_req(13'h005, 13'd0);
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("single_valid", out_valid, 1);
    check("single_last", out_last, 1);
    check("single_data", out_data, 32'h05);
    check("single_ready_low", req_ready, 0);
    @(posedge clk); #1;
    check("single_ready_back", req_ready, 1);
    check("single_busy", busy, 0);
    wait_done();

    // Toggled out_ready, with ignored requests mid-burst
    ready_mode = 1;
    send_req(13'h000, 13'd7);
    repeat (3) @(posedge clk);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 13'h100;
    req_len   = 13'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ignore_req_ready", req_ready, 0);
    end
    req_valid = 1'b0;
    wait_done();
    ready_mode = 0;

    // Back-pressure: two reads then stop
    ready_mode = 2;
    repeat (2) @(posedge clk);
    send_req(13'h040, 13'd5);
    repeat (10) @(posedge clk);
    #1;
    check("bp_rom_addr", rom_addr, 13'h042);
    check("bp_valid", out_valid, 1);
    check("bp_data", out_data, 32'h40);
    @(posedge clk); #1;
    check("bp_rom_addr_hold", rom_addr, 13'h042);
    ready_mode = 0;
    wait_done();

    // Reset mid-burst after three bytes
    k = n_popped;
    send_req(13'h020, 13'd7);
    for (int i = 0; i < 50 && n_popped < k + 3; i++) @(negedge clk);
    check("mid_three_popped", n_popped - k, 3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_quiet", out_valid, 0);
    end
    send_req(13'h030, 13'd2);
    wait_done();

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
